// File: rtl/pc_pkg.sv
// Shared types and default parameters for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned DEF_PC_W      = 10;
  localparam int unsigned DEF_STEP      = 1;
  localparam int unsigned DEF_RESET_VEC = 'h000;
  localparam int unsigned DEF_TRAP_VEC  = 'h3F0;
  localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: push wraps over the oldest entry when full,
// replace rewrites the top in place (call and return in the same cycle).
module ras_stack #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            replace_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: combinational blocks assign defaults first so no path leaves a latch.
    top_d = top_q;
    cnt_d = cnt_q;
    if (push_i) begin
      top_d = top_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && cnt_q != '0) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; the count alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_i)         mem_q[top_d] <= data_i;
      else if (replace_i) mem_q[top_q] <= data_i;
    end
  end

  assign top_o   = mem_q[top_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: increment, branch/call/return redirect,
// trap entry/return with EPC, and a sticky RUN/TRAP/HALT control FSM.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = DEF_PC_W,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned RESET_VEC = DEF_RESET_VEC,
  parameter int unsigned TRAP_VEC  = DEF_TRAP_VEC,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            taken,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] br_addr,
  input  logic            trap,
  input  logic            trap_ret,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] epc,
  output logic            halted,
  output logic            in_trap,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow,
  output logic            double_fault
);

  pc_state_e       state_q, state_d, prior_q, prior_d;
  logic [PC_W-1:0] pc_q, pc_d, epc_q, epc_d, pc_inc, ras_top;
  logic            df_q, df_d, unf_q, unf_d;
  logic            ras_push, ras_pop, ras_replace;

  assign pc_inc = pc_q + PC_W'(STEP);

  always_comb begin
    state_d     = state_q;
    prior_d     = prior_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    df_d        = df_q;
    unf_d       = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    case (state_q)
      HALT: begin
        // A double fault pins the FSM in HALT until reset.
        if (resume && !df_q) state_d = prior_q;
      end
      default: begin
        if (halt_req) begin
          state_d = HALT;
          prior_d = state_q;
        end else if (trap) begin
          if (state_q == RUN) begin
            epc_d   = pc_q;
            pc_d    = PC_W'(TRAP_VEC);
            state_d = TRAP;
          end else begin
            df_d    = 1'b1;
            state_d = HALT;
            prior_d = TRAP;
          end
        end else if (stall) begin
          pc_d = pc_q;
        end else if (trap_ret && state_q == TRAP) begin
          pc_d    = epc_q;
          state_d = RUN;
        end else if (ret) begin
          if (!ras_empty) begin
            pc_d = ras_top;
            if (taken && call) ras_replace = 1'b1;
            else               ras_pop     = 1'b1;
          end else begin
            pc_d  = br_addr;
            unf_d = 1'b1;
          end
        end else if (taken) begin
          pc_d     = br_addr;
          ras_push = call;
        end else begin
          pc_d = pc_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      prior_q <= RUN;
      pc_q    <= PC_W'(RESET_VEC);
      epc_q   <= '0;
      df_q    <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prior_q <= prior_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      df_q    <= df_d;
      unf_q   <= unf_d;
    end
  end

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push_i    (ras_push),
    .pop_i     (ras_pop),
    .replace_i (ras_replace),
    .data_i    (pc_inc),
    .top_o     (ras_top),
    .empty_o   (ras_empty),
    .full_o    (ras_full)
  );

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign halted        = (state_q == HALT);
  assign in_trap       = (state_q == TRAP);
  assign ras_underflow = unf_q;
  assign double_fault  = df_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with hand-computed expected PCs and flags.
module tb_pc_gen;

  logic       clk = 1'b0;
  logic       rst, stall, taken, call, ret, trap, trap_ret, halt_req, resume;
  logic [9:0] br_addr;
  logic [9:0] pc, epc;
  logic       halted, in_trap, ras_empty, ras_full, ras_underflow, double_fault;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .PC_W(10), .STEP(1), .RESET_VEC('h000), .TRAP_VEC('h3F0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .taken(taken), .call(call), .ret(ret),
    .br_addr(br_addr), .trap(trap), .trap_ret(trap_ret), .halt_req(halt_req),
    .resume(resume), .pc(pc), .epc(epc), .halted(halted), .in_trap(in_trap),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; taken = 0; call = 0; ret = 0; trap = 0;
    trap_ret = 0; halt_req = 0; resume = 0; br_addr = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1;
    step(); step();
    check("rst_pc", pc, 0);
    check("rst_epc", epc, 0);
    check("rst_halted", halted, 0);
    check("rst_in_trap", in_trap, 0);
    check("rst_ras_empty", ras_empty, 1);
    check("rst_ras_full", ras_full, 0);
    check("rst_underflow", ras_underflow, 0);
    check("rst_double_fault", double_fault, 0);

    // 1. free-run increment and wrap
    rst = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("inc_pc", pc, i);
    end
    taken = 1; br_addr = 'h3FE;
    step(); check("hold_3fe_a", pc, 'h3FE);
    step(); check("hold_3fe_b", pc, 'h3FE);
    idle();
    step(); check("wrap_3ff", pc, 'h3FF);
    step(); check("wrap_000", pc, 'h000);

    // 2. branch and stall
    step(); step(); step();
    check("pc_at_3", pc, 3);
    taken = 1; br_addr = 100;
    step(); check("branch_100", pc, 100);
    idle();
    step(); check("inc_101", pc, 101);
    stall = 1; taken = 1; br_addr = 500;
    step(); check("stall_a", pc, 101);
    step(); check("stall_b", pc, 101);
    idle();
    step(); check("after_stall", pc, 102);

    // 3. call and return
    taken = 1; br_addr = 5;
    step(); check("jump_5", pc, 5);
    call = 1; br_addr = 200;
    step(); check("call_200", pc, 200);
    check("call_ras_nonempty", ras_empty, 0);
    idle();
    step(); step(); check("pc_202", pc, 202);
    ret = 1;
    step(); check("ret_6", pc, 6);
    check("ret_ras_empty", ras_empty, 1);

    // 4. five nested calls overflow; returns 331,321,311,301 then underflow
    for (int i = 0; i < 5; i++) begin
      idle(); taken = 1; call = 1; br_addr = 10'(300 + 10 * i);
      step(); check("nest_call_pc", pc, 300 + 10 * i);
      check("nest_full", ras_full, (i >= 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      idle(); ret = 1; br_addr = 77;
      step(); check("nest_ret_pc", pc, 331 - 10 * i);
      check("nest_ret_unf", ras_underflow, 0);
    end
    check("nest_drained", ras_empty, 1);
    step(); check("underflow_pc", pc, 77);
    check("underflow_pulse", ras_underflow, 1);
    check("underflow_still_empty", ras_empty, 1);
    idle();
    step(); check("underflow_clear", ras_underflow, 0);
    check("after_underflow_pc", pc, 78);

    // 5. trap, trap return, double fault
    taken = 1; br_addr = 'h123;
    step(); check("jump_123", pc, 'h123);
    idle(); trap = 1;
    step(); check("trap_pc", pc, 'h3F0);
    check("trap_epc", epc, 'h123);
    check("trap_in_trap", in_trap, 1);
    idle();
    step(); check("trap_inc", pc, 'h3F1);
    trap_ret = 1;
    step(); check("trap_ret_pc", pc, 'h123);
    check("trap_ret_run", in_trap, 0);
    idle(); trap = 1;
    step(); check("trap2_pc", pc, 'h3F0);
    step(); check("df_flag", double_fault, 1);
    check("df_halted", halted, 1);
    check("df_pc_hold", pc, 'h3F0);
    check("df_epc_hold", epc, 'h123);
    idle(); resume = 1;
    step(); check("df_resume_ignored", halted, 1);
    check("df_resume_pc", pc, 'h3F0);
    rst = 1;
    step(); check("rst_mid_pc", pc, 0);
    check("rst_mid_df", double_fault, 0);
    check("rst_mid_halted", halted, 0);
    rst = 0; idle();

    // 6. halt and resume
    taken = 1; br_addr = 7;
    step(); check("jump_7", pc, 7);
    idle(); halt_req = 1;
    step(); check("halt_enter", halted, 1);
    check("halt_pc", pc, 7);
    idle(); taken = 1; br_addr = 50;
    for (int i = 0; i < 3; i++) begin
      step(); check("halt_frozen_pc", pc, 7);
    end
    idle(); resume = 1;
    step(); check("resume_run", halted, 0);
    check("resume_pc", pc, 7);
    idle();
    step(); check("resume_inc", pc, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
